// File: rtl/out_addr_gen.sv
// out_addr_gen: write-side address generator for the conv output feature maps.
// Results arrive pixel-major (all channels of one window position, then the
// next position). They are written into channel-planar BRAM using counters
// and adders only. The plane size is built by repeated addition during SETUP.
module out_addr_gen #(
    parameter int BRAM_ADDR_BIT = 32,
    parameter int DATA_BIT      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [11:0]              width,
    input  logic [1:0]               stride,
    input  logic [11:0]              channel,
    input  logic [BRAM_ADDR_BIT-1:0] base,
    input  logic                     in_valid,
    input  logic [DATA_BIT-1:0]      in_data,
    output logic                     in_ready,
    output logic                     bram_we,
    output logic [BRAM_ADDR_BIT-1:0] bram_addr,
    output logic [DATA_BIT-1:0]      bram_din,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t                   state_q;
    logic [11:0]              out_w_q, chan_q, setup_cnt_q;
    logic [11:0]              ch_cnt_q, col_cnt_q, row_cnt_q;
    logic [BRAM_ADDR_BIT-1:0] base_q, plane_q, pix_addr_q, ch_addr_q;
    logic                     in_ready_q, bram_we_q, busy_q, done_q;
    logic [BRAM_ADDR_BIT-1:0] bram_addr_q;
    logic [DATA_BIT-1:0]      bram_din_q;

    logic [11:0] out_w_d;
    logic        degen_d, accept, ch_last, col_last, row_last, setup_last;

    // Output width from the live config, beat acceptance and wrap detection.
    // stride[1] selects stride 2 (covers 2 and 3); otherwise stride 1 (0 and 1).
    always_comb begin
        if (stride[1]) out_w_d = ((width - 12'd3) >> 1) + 12'd1;
        else           out_w_d = width - 12'd2;
        degen_d    = (width < 12'd3) || (channel == 12'd0);
        accept     = in_valid & in_ready_q;
        ch_last    = (ch_cnt_q == chan_q - 12'd1);
        col_last   = (col_cnt_q == out_w_q - 12'd1);
        row_last   = (row_cnt_q == out_w_q - 12'd1);
        setup_last = (setup_cnt_q == out_w_q - 12'd1);
    end

    // Frame FSM, address counters and registered BRAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_w_q     <= '0;
            chan_q      <= '0;
            setup_cnt_q <= '0;
            ch_cnt_q    <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            base_q      <= '0;
            plane_q     <= '0;
            pix_addr_q  <= '0;
            ch_addr_q   <= '0;
            in_ready_q  <= 1'b0;
            bram_we_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            bram_we_q <= accept;
            done_q    <= 1'b0;
            if (accept) begin
                bram_addr_q <= ch_addr_q;
                bram_din_q  <= in_data;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        out_w_q     <= out_w_d;
                        chan_q      <= channel;
                        base_q      <= base;
                        plane_q     <= '0;
                        setup_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        if (degen_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    // out_w additions of out_w give plane = out_w*out_w.
                    plane_q     <= plane_q + BRAM_ADDR_BIT'(out_w_q);
                    setup_cnt_q <= setup_cnt_q + 12'd1;
                    if (setup_last) begin
                        state_q    <= RUN;
                        in_ready_q <= 1'b1;
                        ch_cnt_q   <= '0;
                        col_cnt_q  <= '0;
                        row_cnt_q  <= '0;
                        pix_addr_q <= base_q;
                        ch_addr_q  <= base_q;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!ch_last) begin
                            ch_cnt_q  <= ch_cnt_q + 12'd1;
                            ch_addr_q <= ch_addr_q + plane_q;
                        end else begin
                            // Channel wrap: back to plane 0 at the next pixel.
                            ch_cnt_q   <= '0;
                            pix_addr_q <= pix_addr_q + 1'b1;
                            ch_addr_q  <= pix_addr_q + 1'b1;
                            if (col_last) begin
                                col_cnt_q <= '0;
                                row_cnt_q <= row_cnt_q + 12'd1;
                            end else begin
                                col_cnt_q <= col_cnt_q + 12'd1;
                            end
                            if (col_last && row_last) begin
                                state_q    <= DONE;
                                in_ready_q <= 1'b0;
                                done_q     <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_out_addr_gen.sv
// Bench for out_addr_gen: table of frame configs driven through one task,
// expected writes queued on accepted beats and popped by a write monitor.
module tb_out_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] width;
    logic [1:0]  stride;
    logic [11:0] channel;
    logic [31:0] base;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready, bram_we, busy, done;
    logic [31:0] bram_addr;
    logic [15:0] bram_din;

    out_addr_gen #(.BRAM_ADDR_BIT(32), .DATA_BIT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .width(width), .stride(stride),
        .channel(channel), .base(base), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          width;
        int          stride;
        int          channel;
        logic [31:0] base;
        bit          bp;
        bit          disturb;
        bit          degen;
        int          exp_ow;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   frame  = 0;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL frame %0d %s: got %0h want %0h", frame, nm, got, want);
        end
    endtask

    // Every write must match the oldest accepted beat still outstanding.
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            wr_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL frame %0d unexpected_write: got addr %h data %h want none",
                         frame, bram_addr, bram_din);
            end else begin
                mon_e = sb.pop_front();
                if (bram_addr !== mon_e.addr || bram_din !== mon_e.data) begin
                    errors++;
                    $display("FAIL frame %0d write: got addr %h data %h want addr %h data %h",
                             frame, bram_addr, bram_din, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic run_frame(input vec_t v);
        int   ow, plane, total, beats, cyc, k, ch, row, col;
        exp_t e;
        ow = v.exp_ow; plane = ow * ow; total = plane * v.channel;
        beats = 0; ch = 0; row = 0; col = 0; wr_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; width = 12'(v.width); stride = 2'(v.stride);
        channel = 12'(v.channel); base = v.base;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_t1", 32'(busy), 32'd1);
        if (v.degen) begin
            chk("degen_done_t1", 32'(done), 32'd1);
            chk("degen_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            chk("degen_busy_t2", 32'(busy), 32'd0);
            chk("degen_done_t2", 32'(done), 32'd0);
            chk("degen_writes", 32'(wr_cnt), 32'd0);
            return;
        end
        chk("no_done_setup", 32'(done), 32'd0);
        cyc = 1;
        while (!in_ready && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_latency", 32'(cyc), 32'(ow + 1));
        if (cyc >= 5000) return;
        k = 0;
        while (beats < total && k < 5000) begin
            in_valid = v.bp ? (k % 3 == 0) : 1'b1;
            in_data  = 16'($urandom);
            start    = 1'b0;
            if (v.disturb && k == 4) begin
                start = 1'b1; width = 12'd9; stride = 2'd2; channel = 12'd7; base = 32'h55;
            end
            if (in_valid && in_ready) begin
                e.addr = v.base + 32'(ch * plane + row * ow + col);
                e.data = in_data;
                sb.push_back(e);
                beats++;
                if (ch == v.channel - 1) begin
                    ch = 0;
                    if (col == ow - 1) begin col = 0; row++; end
                    else col++;
                end else begin
                    ch++;
                end
            end
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("beats_timeout", 32'(beats), 32'(total));
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_with_last_we", 32'(bram_we), 32'd1);
        chk("ready_drop", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_clear", 32'(busy), 32'd0);
        chk("write_count", 32'(wr_cnt), 32'(total));
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int   cyc;
        exp_t e;
        vec_t basic0;
        //        width stride ch  base           bp disturb degen ow
        vecs[0] = '{5, 1, 2, 32'h100,      1'b0, 1'b0, 1'b0, 3};
        vecs[1] = '{7, 2, 1, 32'h0,        1'b0, 1'b0, 1'b0, 3};
        vecs[2] = '{6, 2, 1, 32'h0,        1'b0, 1'b0, 1'b0, 2};
        vecs[3] = '{5, 1, 2, 32'h100,      1'b1, 1'b0, 1'b0, 3};
        vecs[4] = '{7, 0, 1, 32'h20,       1'b0, 1'b0, 1'b0, 5};
        vecs[5] = '{8, 3, 3, 32'h40,       1'b0, 1'b0, 1'b0, 3};
        vecs[6] = '{5, 1, 2, 32'h100,      1'b0, 1'b1, 1'b0, 3};
        vecs[7] = '{3, 1, 4, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1};
        vecs[8] = '{5, 1, 0, 32'h100,      1'b0, 1'b0, 1'b1, 0};
        vecs[9] = '{2, 1, 2, 32'h100,      1'b0, 1'b0, 1'b1, 0};
        basic0  = '{5, 1, 2, 32'h0,        1'b0, 1'b0, 1'b0, 3};

        rst = 1'b1; start = 1'b0; width = '0; stride = '0; channel = '0; base = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_bram_we", 32'(bram_we), 32'd0);
        chk("rst_bram_addr", bram_addr, 32'd0);
        chk("rst_bram_din", 32'(bram_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            frame = i;
            run_frame(vecs[i]);
        end

        // Reset in the middle of RUN after five accepted beats.
        frame = 10;
        @(posedge clk); #1;
        start = 1'b1; width = 12'd5; stride = 2'd1; channel = 12'd2; base = 32'h100;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            e.addr   = 32'h100 + 32'((i % 2) * 9 + i / 2);
            e.data   = in_data;
            sb.push_back(e);
            @(negedge clk);
        end
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_bram_we", 32'(bram_we), 32'd0);
        chk("mid_rst_bram_addr", bram_addr, 32'd0);
        chk("mid_rst_bram_din", 32'(bram_din), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sb", 32'(sb.size()), 32'd0);
        rst = 1'b0;

        frame = 11;
        run_frame(basic0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_addr_gen.md
# out_addr_gen

Write-side address generator for the convolution output feature maps. It accepts one result word per handshake from the 3x3 convolution datapath and writes it into output BRAM. The datapath delivers results pixel-major: all output channels of one window position, then the next position. Memory is channel-planar, so the block converts stream order into planar addresses using only counters and adders (no multiplier). It sits between the conv/accumulate stage and the output BRAM port, and mirrors the input-side window address generator.

## Interface
- BRAM_ADDR_BIT, 32, width of output BRAM address.
- DATA_BIT, 16, width of one result word.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- width  in  12  input feature-map width (= height); latched on start.
- stride  in  2  convolution stride; 1 or 2; latched on start.
- channel  in  12  number of output channels; latched on start.
- base  in  BRAM_ADDR_BIT  first output address; latched on start.
- in_valid  in  1  result word valid.
- in_data  in  DATA_BIT  result word.
- in_ready  out  1  block accepts a word this cycle.
- bram_we  out  1  write strobe.
- bram_addr  out  BRAM_ADDR_BIT  write address.
- bram_din  out  DATA_BIT  write data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of frame.

## Operation
- States: IDLE, SETUP, RUN, DONE.
- IDLE -> SETUP on start. Latch width, stride, channel and base. Compute out_w:
  - stride 1: out_w = width-2.
  - stride 2: out_w = ((width-3)>>1)+1.
  - stride 0 is treated as 1; stride 3 is treated as 2.
- If width<3 or channel==0 on start: go IDLE -> DONE directly. No writes occur.
- SETUP: plane = out_w*out_w, computed by adding out_w into an accumulator once per cycle. SETUP lasts exactly out_w cycles, then the block enters RUN.
- RUN: in_ready=1. A beat is accepted when in_valid & in_ready.
- Counters, all cleared on entering RUN:
  - ch_cnt in 0..channel-1.
  - col_cnt and row_cnt in 0..out_w-1.
  - pix_addr = base + row*out_w + col.
  - ch_addr = address of the current beat.
- Beat address = base + ch*plane + row*out_w + col.
- Per accepted beat:
  - If ch_cnt != channel-1: ch_cnt++ and ch_addr += plane.
  - Else: ch_cnt=0, pix_addr++, ch_addr = pix_addr+1, and col_cnt advances. When col wraps to 0, row_cnt++.
- Last beat is ch=channel-1, col=out_w-1, row=out_w-1. RUN -> DONE after accepting it.
- DONE lasts one cycle, with done=1, then the block returns to IDLE.
- start outside IDLE is ignored. Config input changes outside IDLE have no effect.
- Address arithmetic is modulo 2^BRAM_ADDR_BIT; wrap is not flagged.
- Reset, including mid-frame: state IDLE, all counters 0, and no write in the cycle after reset. The partial frame is abandoned.

## Timing
- Reset values: in_ready=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0.
- start sampled at edge t:
  - busy=1 from t+1.
  - SETUP occupies cycles t+1..t+out_w.
  - in_ready=1 from t+out_w+1.
- Write latency is 1 cycle. A beat accepted at edge k produces bram_we=1 with its bram_addr and bram_din registered during cycle k+1.
- bram_we=0 in cycles without an accepted beat. bram_addr and bram_din hold their last values.
- Full throughput: one write per cycle while in_valid stays high. in_valid low stalls the block with no state change.
- in_ready drops in the cycle after the last beat is accepted. That cycle carries both the last bram_we and done=1.
- For the degenerate start (width<3 or channel==0), done pulses at t+1.

## Test plan
- Basic frame: width=5, stride=1, channel=2, base=0x100, continuous in_valid.
  - Requires out_w=3, plane=9, in_ready first at t+4.
  - Addresses must run 0x100,0x109,0x101,0x10A,...,0x108,0x111: 18 writes.
  - done must coincide with the 18th bram_we.
- Stride 2: width=7, channel=1 -> out_w=3, 9 sequential writes 0..8. Then width=6, stride=2 -> out_w=2, 4 writes.
- Backpressure: basic frame with in_valid toggling 1,0,0,1,...
  - Writes occur only the cycle after accepted beats.
  - Address sequence and data order are identical to the basic frame.
- Degenerate: start with channel=0 -> no bram_we, done at t+1, busy low at t+2. Repeat with width=2.
- Reset mid-RUN after 5 beats of the basic frame:
  - All outputs return to reset values next cycle.
  - A new start with base=0 restarts addresses at 0x000.
- start pulsed during RUN: ignored, and the frame completes unchanged. Config inputs changed during RUN: no effect on addresses.
